divisor_ctrl: RTL and testbench

DIVISOR_CTRL -- requirements
Module: divisor_ctrl

---
 rtl/divisor_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_divisor_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divisor_ctrl.sv
// rtl/divisor_ctrl.sv - push-button front end and sequencer for a 4-bit divider
// Optional button debounce is enabled with `define DIVISOR_CTRL_DEBOUNCE_EN.

module divisor_ctrl_btn #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic filled,
    output logic press
);
    logic s1, s2;
    logic lvl, lvl_q, armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef DIVISOR_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] deb_cnt;

    // lvl only follows s2 once it has disagreed for DEB_CYCLES samples in a row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl     <= 1'b1;
            deb_cnt <= '0;
        end else if (s2 == lvl) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
            lvl     <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign lvl = s2;
`endif

    // A button must be seen released after reset before its first press counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            lvl_q <= lvl;
            armed <= armed | (s2 & filled);
        end
    end

    assign press = armed & lvl_q & ~lvl;
endmodule

module divisor_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int WAIT_MAX   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       ok,
    output logic [3:0] num,
    output logic [3:0] den,
    output logic       start,
    input  logic       done,
    input  logic [3:0] quot,
    input  logic [3:0] rem,
    output logic [3:0] leds,
    output logic       busy,
    output logic       err
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        LOAD_NUM,
        LOAD_DEN,
        START,
        WAIT,
        SHOW_Q,
        SHOW_R,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [3:0]    num_n, den_n, q_reg, q_n, r_reg, r_n;
    logic [WW-1:0] wait_cnt, wait_cnt_n;
    logic [1:0]    fill_cnt;
    logic          filled;
    logic          up_p, down_p, ok_p, inc, dec;

    // Synchronizer contents are meaningless until two samples have passed through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fill_cnt <= 2'd0;
        else if (!filled) fill_cnt <= fill_cnt + 2'd1;
    end
    assign filled = (fill_cnt == 2'd2);

    divisor_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn(up), .filled(filled), .press(up_p)
    );
    divisor_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn(down), .filled(filled), .press(down_p)
    );
    divisor_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_ok (
        .clk(clk), .rst(rst), .btn(ok), .filled(filled), .press(ok_p)
    );

    // ok wins over edits; up and down together cancel
    assign inc = up_p & ~down_p & ~ok_p;
    assign dec = down_p & ~up_p & ~ok_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOAD_NUM;
            num      <= 4'd0;
            den      <= 4'd0;
            q_reg    <= 4'd0;
            r_reg    <= 4'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            num      <= num_n;
            den      <= den_n;
            q_reg    <= q_n;
            r_reg    <= r_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        num_n      = num;
        den_n      = den;
        q_n        = q_reg;
        r_n        = r_reg;
        wait_cnt_n = wait_cnt;
        case (state)
            LOAD_NUM: begin
                if (ok_p)     state_n = LOAD_DEN;
                else if (inc) num_n = num + 4'd1;
                else if (dec) num_n = num - 4'd1;
            end
            LOAD_DEN: begin
                if (ok_p)     state_n = (den != 4'd0) ? START : ERR;
                else if (inc) den_n = den + 4'd1;
                else if (dec) den_n = den - 4'd1;
            end
            START: begin
                state_n    = WAIT;
                wait_cnt_n = '0;
            end
            WAIT: begin
                if (done) begin
                    q_n     = quot;
                    r_n     = rem;
                    state_n = SHOW_Q;
                end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                    state_n = ERR;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            SHOW_Q: if (ok_p) state_n = SHOW_R;
            SHOW_R: if (ok_p) state_n = LOAD_NUM;
            ERR:    if (ok_p) state_n = LOAD_NUM;
            default: state_n = LOAD_NUM;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        err   = 1'b0;
        leds  = 4'h0;
        case (state)
            LOAD_NUM: leds = num;
            LOAD_DEN: leds = den;
            START: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            WAIT:   busy = 1'b1;
            SHOW_Q: leds = q_reg;
            SHOW_R: leds = r_reg;
            ERR: begin
                err  = 1'b1;
                leds = 4'hF;
            end
            default: leds = 4'h0;
        endcase
    end
endmodule

// File: tb/tb_divisor_ctrl.sv
// tb/tb_divisor_ctrl.sv - directed self-checking bench for divisor_ctrl

module tb_divisor_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_b = 1'b1, down_b = 1'b1, ok_b = 1'b1;
    logic       done = 1'b0;
    logic [3:0] quot = 4'd0, rem = 4'd0;
    logic [3:0] num, den, leds;
    logic       start, busy, err;
    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;

    divisor_ctrl #(.DEB_CYCLES(4), .WAIT_MAX(64)) dut (
        .clk(clk), .rst(rst), .up(up_b), .down(down_b), .ok(ok_b),
        .num(num), .den(den), .start(start), .done(done),
        .quot(quot), .rem(rem), .leds(leds), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_cnt <= start_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic o);
        up_b = ~u; down_b = ~d; ok_b = ~o;
        repeat (3) tick();
        up_b = 1'b1; down_b = 1'b1; ok_b = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_leds", {28'd0, leds}, 0);
        check("rst_num", {28'd0, num}, 0);
        check("rst_den", {28'd0, den}, 0);
        check("rst_flags", {29'd0, start, busy, err}, 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        // modulo wrap
        press(0, 1, 0);
        check("wrap_down_num", {28'd0, num}, 15);
        check("wrap_down_leds", {28'd0, leds}, 15);
        press(1, 0, 0);
        check("wrap_up_num", {28'd0, num}, 0);

        // two-edge latency, one action per long hold
        up_b = 1'b0;
        tick();
        check("lat_k", {28'd0, num}, 0);
        tick();
        check("lat_k1", {28'd0, num}, 0);
        tick();
        check("lat_k2", {28'd0, num}, 1);
        repeat (7) tick();
        up_b = 1'b1;
        repeat (3) tick();
        check("long_hold", {28'd0, num}, 1);
        press(0, 1, 0);

        // 7 / 2
        for (int i = 0; i < 7; i++) press(1, 0, 0);
        check("num7_leds", {28'd0, leds}, 7);
        press(0, 0, 1);
        check("den_leds0", {28'd0, leds}, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        check("den2_leds", {28'd0, leds}, 2);
        ok_b = 1'b0;
        tick();
        tick();
        check("pre_start", {31'd0, start}, 0);
        tick();
        check("start_hi", {31'd0, start}, 1);
        check("start_busy", {31'd0, busy}, 1);
        check("start_ops", {24'd0, num, den}, 32'h72);
        check("start_leds", {28'd0, leds}, 0);
        tick();
        check("wait_start_lo", {31'd0, start}, 0);
        check("wait_busy", {31'd0, busy}, 1);
        ok_b = 1'b1;
        repeat (4) tick();
        done = 1'b1; quot = 4'd3; rem = 4'd1;
        tick();
        done = 1'b0; quot = 4'd0; rem = 4'd0;
        check("show_q", {28'd0, leds}, 3);
        check("show_q_busy", {31'd0, busy}, 0);
        check("start_count1", start_cnt, 1);
        press(0, 0, 1);
        check("show_r", {28'd0, leds}, 1);
        press(0, 0, 1);
        check("back_num", {28'd0, leds}, 7);
        check("retain_ops", {24'd0, num, den}, 32'h72);

        // button conflicts, then divide by zero
        press(1, 1, 0);
        check("up_down_both", {28'd0, num}, 7);
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 1);
        check("ok_up_leds", {28'd0, leds}, 2);
        check("ok_up_num", {28'd0, num}, 9);
        press(0, 1, 0);
        press(0, 1, 0);
        check("den_zero", {28'd0, den}, 0);
        press(0, 0, 1);
        check("dz_err", {31'd0, err}, 1);
        check("dz_leds", {28'd0, leds}, 15);
        check("dz_nostart", start_cnt, 1);
        press(0, 0, 1);
        check("dz_back", {28'd0, leds}, 9);
        check("dz_err_clr", {31'd0, err}, 0);

        // WAIT timeout
        press(0, 0, 1);
        press(1, 0, 0);
        check("den1", {28'd0, den}, 1);
        ok_b = 1'b0;
        repeat (4) tick();
        check("to_entry_busy", {31'd0, busy}, 1);
        ok_b = 1'b1;
        repeat (63) tick();
        check("to_63_err", {31'd0, err}, 0);
        check("to_63_busy", {31'd0, busy}, 1);
        tick();
        check("to_64_err", {31'd0, err}, 1);
        check("to_64_leds", {28'd0, leds}, 15);
        done = 1'b1; quot = 4'd5;
        tick();
        done = 1'b0; quot = 4'd0;
        check("late_done", {27'd0, err, leds}, 32'h1F);
        press(0, 0, 1);
        check("to_back", {28'd0, leds}, 9);

        // reset mid-WAIT
        press(0, 0, 1);
        press(0, 0, 1);
        check("mid_wait_busy", {31'd0, busy}, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_flags", {29'd0, start, busy, err}, 0);
        check("arst_vals", {20'd0, leds, num, den}, 0);
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        done = 1'b1; quot = 4'd5; rem = 4'd2;
        tick();
        done = 1'b0;
        check("post_rst_done", {27'd0, busy, leds}, 0);
        repeat (2) tick();
        press(1, 0, 0);
        check("post_rst_load", {28'd0, leds}, 1);

        // button held through reset
        up_b = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        check("held_rst", {28'd0, num}, 0);
        up_b = 1'b1;
        repeat (4) tick();
        check("held_release", {28'd0, num}, 0);
        press(1, 0, 0);
        check("held_repress", {28'd0, num}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
